// File: rtl/aes_pkg.sv
// Shared AES helpers: S-boxes, GF(2^8) arithmetic, Rcon table, FSM state type
// and the single-step forward key expansion.
package aes_pkg;

  localparam int unsigned BLK_W = 128;

  typedef enum logic [2:0] {IDLE, KEYEXP, READY, DEC, DONE} state_t;

  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // Each row holds 16 consecutive entries, entry 0 in the top byte
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [127:0] row;
    row = '0;
    case (b[7:4])
      4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
      4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
    endcase
    return row[8*(15 - int'(b[3:0])) +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [127:0] row;
    row = '0;
    case (b[7:4])
      4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
      4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
      4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
      4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
      4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
      4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
      4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
      4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
      4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
      4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
      4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
      4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
      4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
      4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
      4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
      4'hf: row = 128'h172b047eba77d626e169146355210c7d;
    endcase
    return row[8*(15 - int'(b[3:0])) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // One forward expansion step: round key i from round key i-1
  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes128_decrypt_iter_if.sv
// Key, ciphertext-in and plaintext-out handshakes of the iterative decryptor.
interface aes128_decrypt_iter_if;
  import aes_pkg::*;

  logic             key_load;
  logic [BLK_W-1:0] key;
  logic             key_ready;
  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] datain;
  logic             out_valid;
  logic             out_ready;
  logic [BLK_W-1:0] dataout;

  modport master (output key_load, key, in_valid, datain, out_ready,
                  input  key_ready, in_ready, out_valid, dataout);
  modport slave  (input  key_load, key, in_valid, datain, out_ready,
                  output key_ready, in_ready, out_valid, dataout);
endinterface

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the last round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] state,
  input  logic [BLK_W-1:0] round_key,
  input  logic             last_round,
  output logic [BLK_W-1:0] next_state
);

  logic [BLK_W-1:0] sub;
  logic [BLK_W-1:0] ark;
  logic [BLK_W-1:0] mixed;

  // Byte i sits at row i%4, column i/4; row r is rotated right by r columns
  for (genvar i = 0; i < 16; i++) begin : g_isb
    localparam int unsigned R   = i % 4;
    localparam int unsigned SRC = R + 4 * (((i / 4) + 4 - R) % 4);
    assign sub[127-8*i -: 8] = inv_sbox(state[127-8*SRC -: 8]);
  end

  assign ark = sub ^ round_key;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = ark[127-32*c -: 8];
    assign a1 = ark[119-32*c -: 8];
    assign a2 = ark[111-32*c -: 8];
    assign a3 = ark[103-32*c -: 8];
    assign mixed[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
    assign mixed[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
    assign mixed[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
    assign mixed[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
  end

  assign next_state = last_round ? ark : mixed;

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryptor: expands the key once into a round-key file, then
// runs one inverse round per clock for each accepted ciphertext block.
module aes128_decrypt_iter
  import aes_pkg::*;
#(
  parameter int unsigned NR = 10,
  parameter int unsigned DW = 128
) (
  input logic                 clk,
  input logic                 rst,
  aes128_decrypt_iter_if.slave bus
);

  if (NR != 10 || DW != BLK_W) begin : g_param_check
    $error("aes128_decrypt_iter supports only NR=10 and DW=128");
  end

  state_t           st;
  logic [3:0]       cnt;
  logic [BLK_W-1:0] rk [0:NR];
  logic [BLK_W-1:0] blk;
  logic [BLK_W-1:0] rnd_out;
  logic             key_ready;
  logic             out_valid;
  logic [BLK_W-1:0] dataout;

  aes_inv_round u_inv_round (
    .state      (blk),
    .round_key  (rk[cnt]),
    .last_round (cnt == 4'd0),
    .next_state (rnd_out)
  );

  // A key_load in READY takes priority, so the block must not see ready then
  assign bus.in_ready  = (st == READY) && !bus.key_load;
  assign bus.key_ready = key_ready;
  assign bus.out_valid = out_valid;
  assign bus.dataout   = dataout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      cnt       <= '0;
      blk       <= '0;
      key_ready <= 1'b0;
      out_valid <= 1'b0;
      dataout   <= '0;
      for (int i = 0; i <= int'(NR); i++) rk[i] <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (bus.key_load) begin
            rk[0] <= bus.key;
            cnt   <= 4'd1;
            st    <= KEYEXP;
          end
        end
        KEYEXP: begin
          rk[cnt] <= key_step(rk[cnt - 4'd1], RCON[cnt]);
          if (cnt == 4'(NR)) begin
            key_ready <= 1'b1;
            cnt       <= '0;
            st        <= READY;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        READY: begin
          if (bus.key_load) begin
            rk[0]     <= bus.key;
            cnt       <= 4'd1;
            key_ready <= 1'b0;
            st        <= KEYEXP;
          end else if (bus.in_valid) begin
            blk <= bus.datain ^ rk[NR];
            cnt <= 4'(NR - 1);
            st  <= DEC;
          end
        end
        DEC: begin
          if (cnt == 4'd0) begin
            dataout   <= rnd_out;
            out_valid <= 1'b1;
            st        <= DONE;
          end else begin
            blk <= rnd_out;
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            st        <= READY;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Self-checking bench for aes128_decrypt_iter using FIPS-197 vectors and a
// queue of expected plaintexts filled at accept time.
module tb_aes128_decrypt_iter;

  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [127:0] sb_q [$];

  aes128_decrypt_iter_if bus ();

  aes128_decrypt_iter #(.NR(10), .DW(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k, output int lat);
    bus.key      = k;
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bus.key_ready) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic send_block(input logic [127:0] ct, output bit ok);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.datain   = ct;
    while (!bus.in_ready && n < 30) begin
      tick();
      n++;
    end
    ok = bus.in_ready;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  function automatic logic [127:0] pop_exp();
    if (sb_q.size() == 0) return 'x;
    return sb_q.pop_front();
  endfunction

  task automatic test_reset();
    tick();
    tick();
    n_cmp++; if (bus.key_ready !== 1'b0) begin n_bad++; $display("FAIL reset_key_ready got %b want 0", bus.key_ready); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.dataout !== 128'h0) begin n_bad++; $display("FAIL reset_dataout got %h want 0", bus.dataout); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_idle_no_key();
    bus.in_valid = 1'b1;
    bus.datain   = CT_B;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_cmp++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_ignore cyc %0d got in_ready=%b out_valid=%b want 0/0", i, bus.in_ready, bus.out_valid);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_fips_b();
    int lat;
    bit ok;
    logic [127:0] exp;
    bus.out_ready = 1'b1;
    load_key(KEY_B, lat);
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL b_key_latency got %0d want 10", lat); end
    n_cmp++; if (dut.rk[10] !== RK10_B) begin n_bad++; $display("FAIL b_rk10 got %h want %h", dut.rk[10], RK10_B); end
    send_block(CT_B, ok);
    if (ok) sb_q.push_back(PT_B);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b_accept got %b want 1", ok); end
    wait_out(lat);
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL b_out_latency got %0d want 10", lat); end
    if (lat > 0) begin
      exp = pop_exp();
      n_cmp++; if (bus.dataout !== exp) begin n_bad++; $display("FAIL b_dataout got %h want %h", bus.dataout, exp); end
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b_return_ready got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_fips_c1_repeat();
    int lat;
    bit ok;
    logic [127:0] exp;
    load_key(KEY_C, lat);
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL c1_key_latency got %0d want 10", lat); end
    for (int blk = 0; blk < 2; blk++) begin
      send_block(CT_C, ok);
      if (ok) sb_q.push_back(PT_C);
      wait_out(lat);
      n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL c1_out_latency blk %0d got %0d want 10", blk, lat); end
      if (lat > 0) begin
        exp = pop_exp();
        n_cmp++; if (bus.dataout !== exp) begin n_bad++; $display("FAIL c1_dataout blk %0d got %h want %h", blk, bus.dataout, exp); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit ok;
    logic [127:0] exp;
    bus.out_ready = 1'b0;
    send_block(CT_C, ok);
    if (ok) sb_q.push_back(PT_C);
    wait_out(lat);
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL bp_out_latency got %0d want 10", lat); end
    exp = pop_exp();
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.datain   = CT_B;
      tick();
      n_cmp++;
      if (bus.dataout !== exp || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold cyc %0d got data=%h ov=%b ir=%b want data=%h ov=1 ir=0",
                 i, bus.dataout, bus.out_valid, bus.in_ready, exp);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_key_change();
    int lat;
    bit ok;
    bit saw_out;
    logic [127:0] exp;
    bus.key      = KEY_B;
    bus.key_load = 1'b1;
    bus.in_valid = 1'b1;
    bus.datain   = CT_B;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL kc_in_ready got %b want 0", bus.in_ready); end
    tick();
    bus.key_load = 1'b0;
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.key_ready !== 1'b0) begin n_bad++; $display("FAIL kc_key_ready_drop got %b want 0", bus.key_ready); end
    lat = -1;
    saw_out = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bus.out_valid) saw_out = 1'b1;
      if (bus.key_ready) begin
        lat = i;
        break;
      end
    end
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL kc_key_latency got %0d want 10", lat); end
    n_cmp++; if (saw_out !== 1'b0) begin n_bad++; $display("FAIL kc_block_accepted got out_valid=%b want 0", saw_out); end
    send_block(CT_B, ok);
    if (ok) sb_q.push_back(PT_B);
    wait_out(lat);
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL kc_out_latency got %0d want 10", lat); end
    if (lat > 0) begin
      exp = pop_exp();
      n_cmp++; if (bus.dataout !== exp) begin n_bad++; $display("FAIL kc_dataout got %h want %h", bus.dataout, exp); end
    end
    tick();
  endtask

  task automatic test_reset_mid_dec();
    int lat;
    bit ok;
    logic [127:0] exp;
    send_block(CT_B, ok);
    if (ok) sb_q.push_back(PT_B);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    #1;
    sb_q.delete();
    n_cmp++;
    if (bus.key_ready !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.dataout !== 128'h0) begin
      n_bad++;
      $display("FAIL mid_reset got kr=%b ir=%b ov=%b data=%h want all 0",
               bus.key_ready, bus.in_ready, bus.out_valid, bus.dataout);
    end
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.datain   = CT_C;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_cmp++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset_ignore cyc %0d got in_ready=%b out_valid=%b want 0/0", i, bus.in_ready, bus.out_valid);
      end
    end
    bus.in_valid = 1'b0;
    load_key(KEY_C, lat);
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL rekey_latency got %0d want 10", lat); end
    send_block(CT_C, ok);
    if (ok) sb_q.push_back(PT_C);
    wait_out(lat);
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL rekey_out_latency got %0d want 10", lat); end
    if (lat > 0) begin
      exp = pop_exp();
      n_cmp++; if (bus.dataout !== exp) begin n_bad++; $display("FAIL rekey_dataout got %h want %h", bus.dataout, exp); end
    end
    tick();
  endtask

  initial begin
    bus.key_load  = 1'b0;
    bus.key       = '0;
    bus.in_valid  = 1'b0;
    bus.datain    = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_idle_no_key();
    test_fips_b();
    test_fips_c1_repeat();
    test_backpressure();
    test_key_change();
    test_reset_mid_dec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
